can_stuff_ctrl: RTL and testbench
=================================

// Module: can_stuff_ctrl
// PURPOSE
//  Sequences CAN bit stuffing (TX) and de-stuffing (RX) over a frame's stuff region, SOF through last CRC bit.
//  Sits between the frame serializer/deserializer and the bit-timing unit, advancing one bit per sample_point.
//  TX: stalls the serializer and inserts complement bits. RX: flags stuff bits for discard and detects stuff errors.
// PARAMETERS
//  STUFF_LEN  5  equal consecutive bits that force a stuff bit (2..7)
//  CNT_W      3  run-length counter width; must hold STUFF_LEN
// PORTS
//  clk               in   1  system clock
//  rst               in   1  asynchronous, active-high reset
//  sample_point      in   1  one-cycle bit-time strobe from bit timing
//  tx_mode           in   1  1=stuff TX stream, 0=check RX stream; latched on frame_start
//  frame_start       in   1  pulse: open stuff region, SOF is the next processed bit
//  abort             in   1  pulse: terminate frame immediately (error/arb loss)
//  stuff_region_end  in   1  qualifies current bit as last bit of CRC sequence
//  data_bit          in   1  TX: next frame bit from serializer
//  data_req          out  1  TX: strobe, data_bit consumed this cycle
//  line_bit          out  1  TX: registered bit to drive onto bus
//  rx_bit            in   1  RX: sampled bus bit
//  rx_valid          out  1  RX: strobe, rx_bit is a frame (non-stuff) bit
//  stuff_active      out  1  strobe: current bit is a stuff bit (inserted or removed)
//  stuff_err         out  1  sticky RX stuff error
//  busy              out  1  stuff region open (ACTIVE or STUFF)
// BEHAVIOUR
//  Reset: state=IDLE, line_bit=1 (recessive), stuff_err=0, busy=0, run count=0, last=1; strobes 0.
//  Priority per edge: rst > abort > frame_start > sample_point.
//  All bit processing happens only in cycles with sample_point=1. Strobes are combinational in that cycle.
//  States: IDLE, ACTIVE, STUFF (stuff bit due at next sample), ERR.
//  IDLE: line_bit held 1, sample_point ignored. frame_start -> ACTIVE, count=0, mode latched, stuff_err cleared.
//  frame_start coincident with sample_point: that sample is ignored and the first bit is the next sample.
//  ACTIVE, TX: data_req=1. line_bit<=data_bit at the edge.
//   Run count: count<=(data_bit==last && count!=0) ? count+1 : 1; last<=data_bit.
//  ACTIVE, RX: rx_valid=1. Count and last are updated from rx_bit the same way.
//  If the updated count==STUFF_LEN -> STUFF, else remain ACTIVE.
//  If stuff_region_end=1 and no stuff is due -> IDLE, line_bit<=1.
//  Region end is latched as pending_end so a due stuff bit is still handled after the last CRC bit.
//  STUFF, TX: data_req=0, stuff_active=1, line_bit<=~last. count<=1, last<=~last.
//   Then -> IDLE if pending_end, else -> ACTIVE.
//  STUFF, RX: stuff_active=1, rx_valid=0.
//   If rx_bit!=last: count<=1, last<=rx_bit, next state as for TX.
//   If rx_bit==last: stuff_err<=1 and -> ERR.
//  ERR: busy=0, stuff_err held, strobes 0. Leave only via frame_start (-> ACTIVE) or abort/rst (-> IDLE).
//  abort: -> IDLE, line_bit<=1, count=0, pending_end=0. stuff_err is kept (cleared by frame_start/rst).
//  frame_start while busy: restart the frame (count=0, re-latch mode); no stuff bit emitted.
//  Count saturates at STUFF_LEN; it never wraps.
// TESTING
//  TX data 1,1,1,1,1,1 -> line_bit 1,1,1,1,1,0,1.
//   data_req low and stuff_active high on the 6th sample only.
//  RX rx_bit 0,0,0,0,0,1,0 -> rx_valid on samples 1-5 and 7.
//   Sample 6 has stuff_active=1, rx_valid=0, stuff_err=0.
//  RX six 0s -> stuff_err=1 after sample 6, state ERR, busy=0.
//   A following frame_start clears stuff_err.
//  TX region end: stuff_region_end with 5th equal 0 -> stuff bit 1 still sent.
//   Then busy=0 and line_bit=1 at the next sample.
//  TX/RX 24 alternating bits 1010... -> no stuff_active; data_req/rx_valid on every sample.
//  rst asserted in STUFF -> line_bit=1, busy=0, stuff_err=0 immediately (async).
//   abort mid-frame -> IDLE at next edge.

Source files
------------

// File: rtl/can_stuff_ctrl.sv
// CAN bit-stuffing sequencer: inserts complement bits on TX and flags or removes stuff bits on RX,
// advancing one bit per sample_point over the SOF..CRC stuff region.
module can_stuff_ctrl #(
    parameter int STUFF_LEN = 5,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_point,
    input  logic tx_mode,
    input  logic frame_start,
    input  logic abort,
    input  logic stuff_region_end,
    input  logic data_bit,
    output logic data_req,
    output logic line_bit,
    input  logic rx_bit,
    output logic rx_valid,
    output logic stuff_active,
    output logic stuff_err,
    output logic busy
);

    typedef enum logic [1:0] {IDLE, ACTIVE, STUFF, ERR} state_t;

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, run_cnt;
    logic             last, last_d;
    logic             line_d, err_d;
    logic             mode, mode_d;
    logic             pend, pend_d;
    logic             cur_bit;

    assign busy = (state == ACTIVE) || (state == STUFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            line_bit  <= 1'b1;
            stuff_err <= 1'b0;
            mode      <= 1'b0;
            pend      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            last      <= last_d;
            line_bit  <= line_d;
            stuff_err <= err_d;
            mode      <= mode_d;
            pend      <= pend_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        last_d       = last;
        line_d       = line_bit;
        err_d        = stuff_err;
        mode_d       = mode;
        pend_d       = pend;
        data_req     = 1'b0;
        rx_valid     = 1'b0;
        stuff_active = 1'b0;

        cur_bit = mode ? data_bit : rx_bit;
        // count==0 marks the first bit of a frame, which always starts a new run
        if (cur_bit == last && cnt != '0)
            run_cnt = (cnt >= RUN_MAX) ? RUN_MAX : cnt + RUN_ONE;
        else
            run_cnt = RUN_ONE;

        if (abort) begin
            state_d = IDLE;
            line_d  = 1'b1;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else if (frame_start) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            mode_d  = tx_mode;
            err_d   = 1'b0;
            pend_d  = 1'b0;
            line_d  = 1'b1;
        end else if (sample_point) begin
            case (state)
                IDLE: line_d = 1'b1;
                ACTIVE: begin
                    data_req = mode;
                    rx_valid = ~mode;
                    cnt_d    = run_cnt;
                    last_d   = cur_bit;
                    if (mode)
                        line_d = cur_bit;
                    // a due stuff bit outranks region end; the end is remembered for after it
                    if (run_cnt == RUN_MAX) begin
                        state_d = STUFF;
                        pend_d  = stuff_region_end;
                    end else if (stuff_region_end) begin
                        state_d = IDLE;
                        line_d  = 1'b1;
                    end
                end
                STUFF: begin
                    stuff_active = 1'b1;
                    pend_d       = 1'b0;
                    if (mode || rx_bit != last) begin
                        if (mode)
                            line_d = ~last;
                        last_d  = mode ? ~last : rx_bit;
                        cnt_d   = RUN_ONE;
                        state_d = pend ? IDLE : ACTIVE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_can_stuff_ctrl.sv
// Table-driven bench for can_stuff_ctrl: per-cycle vectors with hand-derived strobes and
// post-edge outputs, plus hand-written async reset sequences.
module tb_can_stuff_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sample_point = 1'b0, tx_mode = 1'b0, frame_start = 1'b0, abort = 1'b0;
    logic stuff_region_end = 1'b0, data_bit = 1'b0, rx_bit = 1'b0;
    logic data_req, line_bit, rx_valid, stuff_active, stuff_err, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    can_stuff_ctrl #(.STUFF_LEN(5), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .sample_point(sample_point), .tx_mode(tx_mode),
        .frame_start(frame_start), .abort(abort), .stuff_region_end(stuff_region_end),
        .data_bit(data_bit), .data_req(data_req), .line_bit(line_bit), .rx_bit(rx_bit),
        .rx_valid(rx_valid), .stuff_active(stuff_active), .stuff_err(stuff_err), .busy(busy)
    );

    typedef struct {
        logic fs, ab, sp, tm, d, rx, en;
        logic req, rxv, sa;
        logic line, bsy, err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(logic fs, logic ab, logic sp, logic tm, logic d, logic rx, logic en,
                                logic req, logic rxv, logic sa, logic line, logic bsy, logic err);
        vec_t v;
        v.fs = fs; v.ab = ab; v.sp = sp; v.tm = tm; v.d = d; v.rx = rx; v.en = en;
        v.req = req; v.rxv = rxv; v.sa = sa; v.line = line; v.bsy = bsy; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic step(vec_t v, string tag);
        vec_t e;
        @(negedge clk);
        frame_start = v.fs; abort = v.ab; sample_point = v.sp; tx_mode = v.tm;
        data_bit = v.d; rx_bit = v.rx; stuff_region_end = v.en;
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        chk({tag, " data_req"}, data_req, e.req);
        chk({tag, " rx_valid"}, rx_valid, e.rxv);
        chk({tag, " stuff_active"}, stuff_active, e.sa);
        @(posedge clk);
        #1;
        chk({tag, " line_bit"}, line_bit, e.line);
        chk({tag, " busy"}, busy, e.bsy);
        chk({tag, " stuff_err"}, stuff_err, e.err);
    endtask

    initial begin
        // TX six 1s -> 1,1,1,1,1,0,1 with a non-sample cycle mixed in
        vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,1,1,1,0,0, 1,0,0, 1,1,0));
        vecs.push_back(mk(0,0,0,1,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(0,0,1,1,1,0,0, 1,0,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,1, 0,1,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 1,0,0, 1,1,0));
        vecs.push_back(mk(0,1,1,1,1,0,0, 0,0,0, 1,0,0));
        // RX 0,0,0,0,0,1,0; tx_mode driven high after latch must not matter
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,1,1,1,0,0, 0,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,1,1,0, 0,0,1, 1,1,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,1,0, 1,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 1,0,0));
        // RX six 0s -> stuff error, ERR holds, abort keeps err, frame_start clears it
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,1,0,0,0,0, 0,1,0, 1,1,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,0,1, 1,0,1));
        vecs.push_back(mk(0,0,1,0,0,1,0, 0,0,0, 1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 1,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 1,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 1,0,0));
        // TX region end on 5th equal 0: stuff 1 still sent, then idle
        vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,1,1,0,0,0, 1,0,0, 0,1,0));
        vecs.push_back(mk(0,0,1,1,0,0,1, 1,0,0, 0,1,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,1, 1,0,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0, 1,0,0));
        // TX region end with no stuff due
        vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 1,0,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,0,0,1, 1,0,0, 1,0,0));
        vecs.push_back(mk(0,0,1,1,0,0,0, 0,0,0, 1,0,0));
        // TX 24 alternating bits
        vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 24; i++) begin
            logic b;
            b = (i % 2 == 0);
            vecs.push_back(mk(0,0,1,1,b,0,0, 1,0,0, b,1,0));
        end
        vecs.push_back(mk(0,1,0,1,0,0,0, 0,0,0, 1,0,0));
        // RX 24 alternating bits
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 24; i++) begin
            logic b;
            b = (i % 2 == 0);
            vecs.push_back(mk(0,0,1,0,0,b,0, 0,1,0, 1,1,0));
        end
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0, 1,0,0));
        // restart mid-frame with coincident sample: run count starts over
        vecs.push_back(mk(1,0,0,1,0,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,1,1,1,0,0, 1,0,0, 1,1,0));
        vecs.push_back(mk(1,0,1,1,1,0,0, 0,0,0, 1,1,0));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,1,1,1,0,0, 1,0,0, 1,1,0));
        vecs.push_back(mk(0,0,1,1,1,0,0, 0,0,1, 0,1,0));
        // abort wins over a coincident sample
        vecs.push_back(mk(0,1,1,1,0,0,0, 0,0,0, 1,0,0));

        // reset state
        repeat (2) @(negedge clk);
        sample_point = 1'b1;
        #1;
        chk("reset line_bit", line_bit, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset stuff_err", stuff_err, 1'b0);
        chk("reset data_req", data_req, 1'b0);
        chk("reset stuff_active", stuff_active, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

        // async reset while in STUFF after five TX zeros
        step(mk(1,0,0,1,0,0,0, 0,0,0, 1,1,0), "rs_fs");
        for (int i = 0; i < 5; i++) step(mk(0,0,1,1,0,0,0, 1,0,0, 0,1,0), "rs_tx");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async rst line_bit", line_bit, 1'b1);
        chk("async rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // async reset while in ERR clears the sticky error
        step(mk(1,0,0,0,0,0,0, 0,0,0, 1,1,0), "re_fs");
        for (int i = 0; i < 5; i++) step(mk(0,0,1,0,0,1,0, 0,1,0, 1,1,0), "re_rx");
        step(mk(0,0,1,0,0,1,0, 0,0,1, 1,0,1), "re_err");
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async rst stuff_err", stuff_err, 1'b0);
        chk("async rst busy err", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
